// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life engine.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CLEAR,
        UPDATE,
        COPY
    } state_t;

    localparam logic [8:0]  CONWAY_BIRTH   = 9'b000001000;
    localparam logic [8:0]  CONWAY_SURVIVE = 9'b000001100;

    // Feedback taps: bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } nb_offset_t;

    // Neighbour visiting order, one entry per accumulation cycle.
    function automatic nb_offset_t nb_offset(input logic [2:0] i);
        case (i)
            3'd0:    return '{dx: -2'sd1, dy:  2'sd1};
            3'd1:    return '{dx:  2'sd0, dy:  2'sd1};
            3'd2:    return '{dx:  2'sd1, dy:  2'sd1};
            3'd3:    return '{dx: -2'sd1, dy:  2'sd0};
            3'd4:    return '{dx:  2'sd1, dy:  2'sd0};
            3'd5:    return '{dx: -2'sd1, dy: -2'sd1};
            3'd6:    return '{dx:  2'sd0, dy: -2'sd1};
            default: return '{dx:  2'sd1, dy: -2'sd1};
        endcase
    endfunction

endpackage

// File: rtl/life_if.sv
// Control, command and display-read signals of the life engine.
interface life_if #(
    parameter int LOG_W = 6,
    parameter int LOG_H = 5
);
    logic                   run;
    logic                   step;
    logic                   randomize_req;
    logic                   clear;
    logic                   frame_sync;
    logic                   wrap_mode;
    logic [8:0]             birth_mask;
    logic [8:0]             survive_mask;
    logic                   wr_en;
    logic [LOG_W-1:0]       wr_x;
    logic [LOG_H-1:0]       wr_y;
    logic                   wr_data;
    logic [LOG_W-1:0]       rd_x;
    logic [LOG_H-1:0]       rd_y;
    logic                   rd_cell;
    logic                   busy;
    logic                   gen_done;
    logic [15:0]            gen_count;
    logic [LOG_W+LOG_H:0]   population;

    modport master (
        output run, step, randomize_req, clear, frame_sync, wrap_mode,
               birth_mask, survive_mask, wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        input  rd_cell, busy, gen_done, gen_count, population
    );

    modport slave (
        input  run, step, randomize_req, clear, frame_sync, wrap_mode,
               birth_mask, survive_mask, wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        output rd_cell, busy, gen_done, gen_count, population
    );
endinterface

// File: rtl/life_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left, feeding the board randomiser.
module life_lfsr16
    import life_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic        out_bit
);
    logic [15:0] lfsr;

    // Advance every cycle; reload the seed on reset.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= seed;
        else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign out_bit = lfsr[0];
endmodule

// File: rtl/life_engine.sv
// Game of Life core: board storage, generation FSM, randomiser and launch timer.
module life_engine
    import life_pkg::*;
#(
    parameter int          LOG_W           = 6,
    parameter int          LOG_H           = 5,
    parameter int          UPDATE_INTERVAL = 2400000,
    parameter logic [15:0] SEED            = 16'h0001
) (
    input  logic  clk,
    input  logic  reset,
    life_if.slave bus
);
    localparam int LOG_N = LOG_W + LOG_H;
    localparam int N     = 1 << LOG_N;
    localparam int PW    = LOG_N + 1;
    localparam int TW    = $clog2(UPDATE_INTERVAL + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(UPDATE_INTERVAL);

    state_t           state_q, state_d;
    logic [LOG_N-1:0] idx;
    logic [3:0]       sub;
    logic [3:0]       nb_cnt;
    logic [PW-1:0]    pop_acc, population;
    logic [15:0]      gen_count;
    logic             gen_done;
    logic [TW-1:0]    timer;
    logic             wrap_q;
    logic [8:0]       birth_q, survive_q;
    logic             cur [N];
    logic             nxt [N];
    logic             lfsr_bit;

    logic             do_write, do_launch, idx_last, cell_in;
    logic [LOG_N-1:0] wr_idx;
    nb_offset_t       off;
    logic [LOG_W:0]   nx_ext;
    logic [LOG_H:0]   ny_ext;
    logic             nb_alive;

    life_lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (SEED),
        .out_bit (lfsr_bit)
    );

    assign wr_idx   = {bus.wr_y, bus.wr_x};
    assign idx_last = &idx;
    assign cell_in  = (state_q == INIT) ? lfsr_bit : nxt[idx];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= INIT;
        else       state_q <= state_d;
    end

    // Next-state logic and IDLE command arbitration (clear > randomize > write > step > timer).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        do_write  = 1'b0;
        do_launch = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear)              state_d = CLEAR;
                else if (bus.randomize_req) state_d = INIT;
                else if (bus.wr_en)         do_write = 1'b1;
                else if (bus.step || (bus.run && bus.frame_sync && timer == TIMER_MAX)) begin
                    state_d   = UPDATE;
                    do_launch = 1'b1;
                end
            end
            INIT, CLEAR, COPY: if (idx_last) state_d = (state_q == COPY) ? IDLE : IDLE;
            UPDATE:            if (idx_last && sub == 4'd8) state_d = COPY;
            default:           state_d = INIT;
        endcase
    end

    // Neighbour address: out-of-range coordinates set the extra MSB, which matters only without wrap.
    always_comb begin
        off      = nb_offset(sub[2:0]);
        nx_ext   = {1'b0, idx[LOG_W-1:0]}     + {{(LOG_W-1){off.dx[1]}}, off.dx};
        ny_ext   = {1'b0, idx[LOG_N-1:LOG_W]} + {{(LOG_H-1){off.dy[1]}}, off.dy};
        nb_alive = cur[{ny_ext[LOG_H-1:0], nx_ext[LOG_W-1:0]}]
                   && (wrap_q || !(nx_ext[LOG_W] || ny_ext[LOG_H]));
    end

    // Board writes: randomise, clear, copy-back and single-cell edits.
    always_ff @(posedge clk) begin
        // NOTE: the board arrays are not reset; INIT overwrites every cell right after reset.
        if (!reset) begin
            case (state_q)
                INIT:    cur[idx] <= lfsr_bit;
                CLEAR:   cur[idx] <= 1'b0;
                COPY:    cur[idx] <= nxt[idx];
                IDLE:    if (do_write) cur[wr_idx] <= bus.wr_data;
                default: ;
            endcase
        end
    end

    // Next-generation buffer written on the ninth cycle of each cell.
    always_ff @(posedge clk) begin
        if (!reset && state_q == UPDATE && sub == 4'd8)
            nxt[idx] <= cur[idx] ? survive_q[nb_cnt] : birth_q[nb_cnt];
    end

    // Sequencing counters, timer, rule latches and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            sub        <= '0;
            nb_cnt     <= '0;
            pop_acc    <= '0;
            population <= '0;
            gen_count  <= '0;
            gen_done   <= 1'b0;
            timer      <= '0;
            wrap_q     <= 1'b0;
            birth_q    <= CONWAY_BIRTH;
            survive_q  <= CONWAY_SURVIVE;
        end else begin
            gen_done <= 1'b0;
            if (do_launch)                           timer <= '0;
            else if (bus.run && timer != TIMER_MAX)  timer <= timer + TW'(1);

            case (state_q)
                IDLE: begin
                    idx     <= '0;
                    sub     <= '0;
                    nb_cnt  <= '0;
                    pop_acc <= '0;
                    if (do_write && cur[wr_idx] != bus.wr_data)
                        population <= bus.wr_data ? population + PW'(1) : population - PW'(1);
                    if (do_launch) begin
                        wrap_q    <= bus.wrap_mode;
                        birth_q   <= bus.birth_mask;
                        survive_q <= bus.survive_mask;
                    end
                end
                INIT, COPY: begin
                    idx     <= idx + LOG_N'(1);
                    pop_acc <= pop_acc + PW'(cell_in);
                    if (idx_last) begin
                        population <= pop_acc + PW'(cell_in);
                        pop_acc    <= '0;
                        if (state_q == COPY) begin
                            gen_count <= gen_count + 16'd1;
                            gen_done  <= 1'b1;
                        end else begin
                            gen_count <= '0;
                        end
                    end
                end
                CLEAR: begin
                    idx <= idx + LOG_N'(1);
                    if (idx_last) begin
                        population <= '0;
                        gen_count  <= '0;
                    end
                end
                UPDATE: begin
                    if (sub == 4'd8) begin
                        sub    <= '0;
                        nb_cnt <= '0;
                        idx    <= idx + LOG_N'(1);
                    end else begin
                        sub    <= sub + 4'd1;
                        nb_cnt <= nb_cnt + 4'(nb_alive);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.rd_cell    = cur[{bus.rd_y, bus.rd_x}];
    assign bus.gen_done   = gen_done;
    assign bus.gen_count  = gen_count;
    assign bus.population = population;
endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine on a 16x8 board.
`timescale 1ns/1ps
module tb_life_engine;
    import life_pkg::*;

    localparam int          LOG_W = 4;
    localparam int          LOG_H = 3;
    localparam int          W     = 16;
    localparam int          N     = 128;
    localparam int          GEN_CYCLES = 9 * N + N;
    localparam logic [15:0] SEED  = 16'h0001;

    logic clk = 1'b0;
    logic reset;

    life_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();

    life_engine #(
        .LOG_W           (LOG_W),
        .LOG_H           (LOG_H),
        .UPDATE_INTERVAL (16),
        .SEED            (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic init_board [N];
    int   init_pop;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Software LFSR model of the board produced by INIT right after reset.
    task automatic build_init_model();
        logic [15:0] s;
        s        = SEED;
        init_pop = 0;
        for (int k = 0; k < N; k++) begin
            init_board[k] = s[0];
            init_pop     += int'(s[0]);
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
    endtask

    task automatic read_board(output logic b [N]);
        for (int k = 0; k < N; k++) begin
            bus.rd_x = 4'(k % W);
            bus.rd_y = 3'(k / W);
            #1;
            b[k] = bus.rd_cell;
        end
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (bus.busy && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic write_cell(input int x, input int y, input logic d);
        bus.wr_x    = 4'(x);
        bus.wr_y    = 3'(y);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_clear();
        int c;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        wait_idle(1000, c);
    endtask

    task automatic run_gen(output int cycles);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        cycles = 0;
        while (!bus.gen_done && cycles < 3000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int   c, errs;
        logic b [N];
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, expected 1", bus.busy); end
        n_checks++;
        if (bus.gen_count !== 16'd0 || bus.population !== 8'd0 || bus.gen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: gen_count=%0d population=%0d gen_done=%b, expected 0/0/0",
                     bus.gen_count, bus.population, bus.gen_done);
        end
        reset = 1'b0;
        wait_idle(1000, c);
        n_checks++;
        if (c !== N) begin n_fail++; $display("FAIL init_duration: got %0d cycles, expected %0d", c, N); end
        read_board(b);
        errs = 0;
        for (int k = 0; k < N; k++) if (b[k] !== init_board[k]) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL init_board: %0d cells differ, expected 0", errs); end
        n_checks++;
        if (bus.population !== 8'(init_pop)) begin
            n_fail++; $display("FAIL init_population: got %0d, expected %0d", bus.population, init_pop);
        end
    endtask

    // clear and step in the same cycle: clear wins, step is not remembered.
    task automatic test_clear();
        int   c, errs;
        logic b [N];
        bus.clear = 1'b1;
        bus.step  = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.step  = 1'b0;
        wait_idle(1000, c);
        n_checks++;
        if (c !== N) begin n_fail++; $display("FAIL clear_duration: got %0d cycles, expected %0d", c, N); end
        read_board(b);
        errs = 0;
        for (int k = 0; k < N; k++) if (b[k] !== 1'b0) errs++;
        n_checks++;
        if (errs !== 0 || bus.population !== 8'd0 || bus.gen_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_board: live=%0d population=%0d gen_count=%0d, expected 0/0/0",
                     errs, bus.population, bus.gen_count);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clear_priority: busy=%b, expected 0", bus.busy); end
    endtask

    task automatic test_write_pop();
        write_cell(5, 4, 1'b1);
        n_checks++;
        if (bus.population !== 8'd1) begin n_fail++; $display("FAIL wr_set: population %0d, expected 1", bus.population); end
        write_cell(5, 4, 1'b1);
        write_cell(9, 2, 1'b0);
        n_checks++;
        if (bus.population !== 8'd1) begin n_fail++; $display("FAIL wr_nochange: population %0d, expected 1", bus.population); end
        write_cell(6, 4, 1'b1);
        write_cell(7, 4, 1'b1);
        write_cell(7, 4, 1'b0);
        write_cell(7, 4, 1'b1);
        n_checks++;
        if (bus.population !== 8'd3) begin n_fail++; $display("FAIL wr_three: population %0d, expected 3", bus.population); end
    endtask

    // Blinker, with mask changes and dropped commands injected mid-generation.
    task automatic test_blinker();
        int   c, errs;
        logic b [N];
        logic e [N];
        for (int k = 0; k < N; k++) e[k] = 1'b0;
        e[3*W+6] = 1'b1;
        e[4*W+6] = 1'b1;
        e[5*W+6] = 1'b1;
        bus.wrap_mode = 1'b1;
        bus.step      = 1'b1;
        tick();
        bus.step    = 1'b0;
        bus.wr_x    = 4'd0;
        bus.wr_y    = 3'd0;
        bus.wr_data = 1'b1;
        c = 0;
        while (!bus.gen_done && c < 3000) begin
            if (c == 4) begin
                bus.birth_mask   = 9'd0;
                bus.survive_mask = 9'd0;
                bus.wrap_mode    = 1'b0;
            end
            bus.clear = (c == 5);
            bus.wr_en = (c == 6);
            bus.step  = (c == 7);
            tick();
            c++;
        end
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.step = 1'b0;
        bus.birth_mask = CONWAY_BIRTH; bus.survive_mask = CONWAY_SURVIVE; bus.wrap_mode = 1'b1;
        n_checks++;
        if (c !== GEN_CYCLES) begin n_fail++; $display("FAIL blinker_latency: got %0d, expected %0d", c, GEN_CYCLES); end
        n_checks++;
        if (bus.gen_count !== 16'd1 || bus.population !== 8'd3) begin
            n_fail++; $display("FAIL blinker_stats: gen_count=%0d population=%0d, expected 1/3", bus.gen_count, bus.population);
        end
        read_board(b);
        errs = 0;
        for (int k = 0; k < N; k++) if (b[k] !== e[k]) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL blinker_board: %0d cells differ, expected 0", errs); end
        tick();
        n_checks++;
        if (bus.gen_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL blinker_after: gen_done=%b busy=%b, expected 0/0", bus.gen_done, bus.busy);
        end
    endtask

    // Blinker straddling x=0 on row 0; without wrap both fragments die out.
    task automatic test_edges();
        int   c, errs;
        logic b [N];
        logic e [N];
        for (int wrap = 1; wrap >= 0; wrap--) begin
            for (int k = 0; k < N; k++) e[k] = 1'b0;
            if (wrap == 1) begin
                e[7*W+0] = 1'b1;
                e[0]     = 1'b1;
                e[1*W+0] = 1'b1;
            end
            pulse_clear();
            write_cell(0, 0, 1'b1);
            write_cell(1, 0, 1'b1);
            write_cell(15, 0, 1'b1);
            bus.wrap_mode = (wrap == 1);
            run_gen(c);
            n_checks++;
            if (c !== GEN_CYCLES || bus.gen_count !== 16'd1) begin
                n_fail++; $display("FAIL edge_gen wrap=%0d: cycles=%0d gen_count=%0d, expected %0d/1",
                                   wrap, c, bus.gen_count, GEN_CYCLES);
            end
            n_checks++;
            if (bus.population !== 8'(3 * wrap)) begin
                n_fail++; $display("FAIL edge_pop wrap=%0d: got %0d, expected %0d", wrap, bus.population, 3 * wrap);
            end
            read_board(b);
            errs = 0;
            for (int k = 0; k < N; k++) if (b[k] !== e[k]) errs++;
            n_checks++;
            if (errs !== 0) begin n_fail++; $display("FAIL edge_board wrap=%0d: %0d cells differ, expected 0", wrap, errs); end
        end
        bus.wrap_mode = 1'b1;
    endtask

    task automatic test_timer();
        int c, bad;
        bus.run        = 1'b1;
        bus.frame_sync = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL timer_nosync: busy for %0d cycles, expected 0", bad); end
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timer_launch: busy=%b, expected 1", bus.busy); end
        wait_idle(3000, c);
        n_checks++;
        if (bus.gen_count !== 16'd2) begin n_fail++; $display("FAIL timer_gen: gen_count=%0d, expected 2", bus.gen_count); end
        bus.run        = 1'b0;
        bus.frame_sync = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL timer_run_off: busy for %0d cycles, expected 0", bad); end
        bus.run = 1'b1;
        tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timer_frozen: busy=%b, expected 1", bus.busy); end
        bus.run        = 1'b0;
        bus.frame_sync = 1'b0;
        wait_idle(3000, c);
    endtask

    task automatic test_rules();
        int   c, live;
        logic b [N];
        bus.randomize_req = 1'b1;
        tick();
        bus.randomize_req = 1'b0;
        wait_idle(1000, c);
        n_checks++;
        if (c !== N || bus.gen_count !== 16'd0) begin
            n_fail++; $display("FAIL rand_init: cycles=%0d gen_count=%0d, expected %0d/0", c, bus.gen_count, N);
        end
        read_board(b);
        live = 0;
        for (int k = 0; k < N; k++) live += int'(b[k]);
        n_checks++;
        if (bus.population !== 8'(live)) begin
            n_fail++; $display("FAIL rand_population: got %0d, expected %0d", bus.population, live);
        end
        bus.birth_mask   = 9'd0;
        bus.survive_mask = 9'd0;
        run_gen(c);
        bus.birth_mask   = CONWAY_BIRTH;
        bus.survive_mask = CONWAY_SURVIVE;
        n_checks++;
        if (c !== GEN_CYCLES || bus.population !== 8'd0 || bus.gen_count !== 16'd1) begin
            n_fail++; $display("FAIL rules_zero: cycles=%0d population=%0d gen_count=%0d, expected %0d/0/1",
                               c, bus.population, bus.gen_count, GEN_CYCLES);
        end
    endtask

    task automatic test_reset_mid();
        int   c, errs;
        logic b [N];
        run_gen(c);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: busy=%b, expected 1", bus.busy); end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.gen_count !== 16'd0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: gen_count=%0d busy=%b, expected 0/1", bus.gen_count, bus.busy);
        end
        wait_idle(1000, c);
        read_board(b);
        errs = 0;
        for (int k = 0; k < N; k++) if (b[k] !== init_board[k]) errs++;
        n_checks++;
        if (c !== N || errs !== 0 || bus.population !== 8'(init_pop)) begin
            n_fail++; $display("FAIL mid_reinit: cycles=%0d diff=%0d population=%0d, expected %0d/0/%0d",
                               c, errs, bus.population, N, init_pop);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.run           = 1'b0;
        bus.step          = 1'b0;
        bus.randomize_req = 1'b0;
        bus.clear         = 1'b0;
        bus.frame_sync    = 1'b0;
        bus.wrap_mode     = 1'b1;
        bus.birth_mask    = CONWAY_BIRTH;
        bus.survive_mask  = CONWAY_SURVIVE;
        bus.wr_en         = 1'b0;
        bus.wr_x          = '0;
        bus.wr_y          = '0;
        bus.wr_data       = 1'b0;
        bus.rd_x          = '0;
        bus.rd_y          = '0;
        build_init_model();

        test_reset();
        test_clear();
        test_write_pop();
        test_blinker();
        test_edges();
        test_timer();
        test_rules();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
